// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: turns the current PC into instruction-memory requests and
// buffers returned words (with their PCs) for the decoder. Only one request is
// in flight at a time, and one is issued only when the buffer is known to have
// room for its response. A flush drops buffered entries and any in-flight
// response.
// Optional build macro FETCH_ALIGN_CHECK_EN: a misaligned PC is not fetched.
// Instead a NOP entry flagged as a fetch fault is queued, and fetch stalls
// until the next flush.
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_enable,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              fetch_fault
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, FLUSH_WAIT} state_e;
  state_e state_q, state_d;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              stall_q, stall_d;

  logic              credit_ok, push, pop;
  logic [DATA_W-1:0] push_data;
  logic [ADDR_W-1:0] push_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);
  logic             push_fault;
  logic [DEPTH-1:0] fault_q;
`endif

  // With at most one request in flight, a free slot now guarantees room for its response.
  assign credit_ok   = (count_q < FULL_CNT);
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready & ~flush;
  assign pc_enable   = mem_req & mem_gnt;

`ifdef FETCH_ALIGN_CHECK_EN
  assign mem_addr    = mem_req ? pc_in : '0;
  assign fetch_fault = instr_valid & fault_q[rd_ptr_q];
`else
  assign mem_addr    = mem_req ? {pc_in[ADDR_W-1:2], 2'b00} : '0;
  assign fetch_fault = 1'b0;
`endif

  // Empty-buffer outputs are forced to zero so stale slots never show through.
  assign instr_out = instr_valid ? data_q[rd_ptr_q] : '0;
  assign instr_pc  = instr_valid ? pc_q[rd_ptr_q]   : '0;

  // Next-state, request and push decode.
  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    stall_d   = stall_q;
    mem_req   = 1'b0;
    push      = 1'b0;
    push_data = mem_rdata;
    push_pc   = pend_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    push_fault = 1'b0;
`endif
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (!flush && !stall_q && credit_ok) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (pc_in[1:0] != 2'b00) begin
            push       = 1'b1;
            push_fault = 1'b1;
            push_data  = NOP;
            push_pc    = pc_in;
            stall_d    = 1'b1;
          end else begin
`endif
            mem_req = 1'b1;
            if (mem_gnt) begin
              pend_pc_d = pc_in;
              state_d   = WAIT_RESP;
            end
`ifdef FETCH_ALIGN_CHECK_EN
          end
`endif
        end
      end
      WAIT_RESP: begin
        if (mem_rvalid) begin
          push    = ~flush;
          state_d = REQ;
        end else if (flush) begin
          state_d = FLUSH_WAIT;
        end
      end
      // The stale response is dropped whenever it arrives. A repeated flush
      // without it keeps waiting, so the state can never hang past that response.
      FLUSH_WAIT: if (mem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (flush) stall_d = 1'b0;
  end

  // FSM and pending-PC registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pend_pc_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
      stall_q   <= stall_d;
    end
  end

  // Buffer pointers and occupancy. Flush wins over a same-cycle push or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Buffer payload storage. It needs no reset because the outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= push_data;
      pc_q[wr_ptr_q]   <= push_pc;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Per-entry fault flag. It is reset so that it is always defined.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  fault_q <= '0;
    else if (push) fault_q[wr_ptr_q] <= push_fault;
  end
`endif

  // The credit check must make a push into a full buffer impossible.
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && count_q == FULL_CNT));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit (DEPTH=2). Every row sets
// the inputs for one cycle and checks the combinational and registered outputs
// within that same cycle, before the next rising edge.
module tb_instr_fetch_unit;
  localparam logic O = 1'b0, I = 1'b1;

  logic        clk, reset_n;
  logic [31:0] pc_in, mem_addr, mem_rdata, instr_out, instr_pc;
  logic        pc_enable, flush, mem_req, mem_gnt, mem_rvalid;
  logic        instr_valid, instr_ready, fetch_fault;

  int n_vec  = 0;
  int n_miss = 0;

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .pc_enable(pc_enable),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;  logic gnt; logic rv; logic [31:0] rd; logic rdy; logic fl;
    logic e_req; logic [31:0] e_addr; logic e_en; logic e_iv;
    logic [31:0] e_out; logic [31:0] e_ipc; logic e_flt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Apply one row, check it, then advance to just after the next rising edge.
  task automatic run(input vec_t v, input string tag);
    pc_in = v.pc; mem_gnt = v.gnt; mem_rvalid = v.rv; mem_rdata = v.rd;
    instr_ready = v.rdy; flush = v.fl;
    #1;
    chk({tag, ".req"},   32'(mem_req),     32'(v.e_req));
    chk({tag, ".addr"},  mem_addr,         v.e_addr);
    chk({tag, ".pcen"},  32'(pc_enable),   32'(v.e_en));
    chk({tag, ".iv"},    32'(instr_valid), 32'(v.e_iv));
    chk({tag, ".out"},   instr_out,        v.e_out);
    chk({tag, ".ipc"},   instr_pc,         v.e_ipc);
    chk({tag, ".fault"}, 32'(fetch_fault), 32'(v.e_flt));
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"},   32'(mem_req),     32'd0);
    chk({tag, ".addr"},  mem_addr,         32'd0);
    chk({tag, ".pcen"},  32'(pc_enable),   32'd0);
    chk({tag, ".iv"},    32'(instr_valid), 32'd0);
    chk({tag, ".out"},   instr_out,        32'd0);
    chk({tag, ".ipc"},   instr_pc,         32'd0);
    chk({tag, ".fault"}, 32'(fetch_fault), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
  endtask

  initial begin
    // Rows:  pc, gnt, rv, rdata, rdy, fl | req, addr, pcen, iv, out, ipc, fault
    // Test 1 (single fetch), then test 2 (back-pressure with DEPTH=2).
    tbl[0]  = '{32'h0,  I, O, 32'h0,        I, O, O, 32'h0,  O, O, 32'h0,        32'h0, O};
    tbl[1]  = '{32'h0,  I, O, 32'h0,        I, O, I, 32'h0,  I, O, 32'h0,        32'h0, O};
    tbl[2]  = '{32'h4,  O, I, 32'h00500093, I, O, O, 32'h0,  O, O, 32'h0,        32'h0, O};
    tbl[3]  = '{32'h4,  I, O, 32'h0,        I, O, I, 32'h4,  I, I, 32'h00500093, 32'h0, O};
    tbl[4]  = '{32'h8,  O, I, 32'h11111111, I, O, O, 32'h0,  O, O, 32'h0,        32'h0, O};
    tbl[5]  = '{32'h8,  I, O, 32'h0,        O, O, I, 32'h8,  I, I, 32'h11111111, 32'h4, O};
    tbl[6]  = '{32'hC,  O, I, 32'h22222222, O, O, O, 32'h0,  O, I, 32'h11111111, 32'h4, O};
    tbl[7]  = '{32'hC,  I, O, 32'h0,        O, O, O, 32'h0,  O, I, 32'h11111111, 32'h4, O};
    tbl[8]  = '{32'hC,  I, O, 32'h0,        I, O, O, 32'h0,  O, I, 32'h11111111, 32'h4, O};
    tbl[9]  = '{32'hC,  I, O, 32'h0,        I, O, I, 32'hC,  I, I, 32'h22222222, 32'h8, O};
    tbl[10] = '{32'h10, O, I, 32'h33333333, I, O, O, 32'h0,  O, O, 32'h0,        32'h0, O};
    tbl[11] = '{32'h10, O, O, 32'h0,        I, O, I, 32'h10, O, I, 32'h33333333, 32'hC, O};

    pc_in = '0; mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    instr_ready = 1'b0; flush = 1'b0;
    do_reset();

    for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Test 3: flush in WAIT_RESP; the late response 0xDEADBEEF must never surface.
    run('{32'h10,  I, O, 32'h0,        I, O, I, 32'h10,  I, O, 32'h0, 32'h0, O}, "t3.grant");
    run('{32'h100, O, O, 32'h0,        I, I, O, 32'h0,   O, O, 32'h0, 32'h0, O}, "t3.flush");
    run('{32'h100, O, O, 32'h0,        I, O, O, 32'h0,   O, O, 32'h0, 32'h0, O}, "t3.fwait");
    run('{32'h100, O, I, 32'hDEADBEEF, I, O, O, 32'h0,   O, O, 32'h0, 32'h0, O}, "t3.stale");
    run('{32'h100, I, O, 32'h0,        I, O, I, 32'h100, I, O, 32'h0, 32'h0, O}, "t3.redir");

    // Test 4a: flush in the same cycle as rvalid, so the data is dropped.
    run('{32'h104, O, I, 32'hBAD0BAD0, I, I, O, 32'h0,   O, O, 32'h0, 32'h0, O}, "t4.flrv");
    run('{32'h200, I, O, 32'h0,        I, O, I, 32'h200, I, O, 32'h0, 32'h0, O}, "t4.req");
    run('{32'h204, O, I, 32'hAAAA0001, I, O, O, 32'h0,   O, O, 32'h0, 32'h0, O}, "t4.rv");
    // Test 4b: flush while the head is being consumed.
    run('{32'h300, I, O, 32'h0,        I, I, O, 32'h0,   O, I, 32'hAAAA0001, 32'h200, O}, "t4.flpop");

    // Test 5: grant withheld for 3 cycles, so the request holds steady without pc_enable.
    for (int k = 0; k < 3; k++)
      run('{32'h300, O, O, 32'h0, I, O, I, 32'h300, O, O, 32'h0, 32'h0, O}, $sformatf("t5.hold%0d", k));
    run('{32'h300, I, O, 32'h0,        O, O, I, 32'h300, I, O, 32'h0, 32'h0, O}, "t5.gnt");
    run('{32'h304, O, I, 32'h55550000, O, O, O, 32'h0,   O, O, 32'h0, 32'h0, O}, "t5.rv");
    run('{32'h304, I, O, 32'h0,        O, O, I, 32'h304, I, I, 32'h55550000, 32'h300, O}, "t5.gnt2");
    // Now in WAIT_RESP holding a buffered entry. Reset asserts between edges.
    mem_gnt = 1'b1; mem_rvalid = 1'b0; #1;
    chk("t5.pre_rst.iv", 32'(instr_valid), 32'd1);
    reset_n = 1'b0; #1;
    chk_all_zero("t5.async_rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    // A response for the pre-reset request arrives in IDLE and must be ignored.
    run('{32'h400, O, I, 32'hCAFEF00D, I, O, O, 32'h0,   O, O, 32'h0, 32'h0, O}, "t5.idle_rv");
    run('{32'h400, O, O, 32'h0,        I, O, I, 32'h400, O, O, 32'h0, 32'h0, O}, "t5.after");

`ifdef FETCH_ALIGN_CHECK_EN
    // Test 6: a misaligned PC queues a faulting NOP and stalls until a flush.
    do_reset();
    run('{32'h102, I, O, 32'h0, O, O, O, 32'h0,   O, O, 32'h0,  32'h0,   O}, "t6.idle");
    run('{32'h102, I, O, 32'h0, O, O, O, 32'h0,   O, O, 32'h0,  32'h0,   O}, "t6.mis");
    run('{32'h102, I, O, 32'h0, O, O, O, 32'h0,   O, I, 32'h13, 32'h102, I}, "t6.fault");
    run('{32'h104, I, O, 32'h0, O, I, O, 32'h0,   O, I, 32'h13, 32'h102, I}, "t6.flush");
    run('{32'h104, O, O, 32'h0, O, O, I, 32'h104, O, O, 32'h0,  32'h0,   O}, "t6.clear");
`else
    // Without the check, a misaligned PC is fetched from the word-aligned address.
    do_reset();
    run('{32'h102, O, O, 32'h0, O, O, O, 32'h0,   O, O, 32'h0, 32'h0, O}, "al.idle");
    run('{32'h102, O, O, 32'h0, O, O, I, 32'h100, O, O, 32'h0, 32'h0, O}, "al.req");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
